// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Purpose : groups the hazard-controller inputs and the stall/flush enables into one bundle.
// Modports: master - pipeline side; drives the hazard sources and receives the enables.
//           slave  - hazard controller; reads the hazard sources and drives the enables.
// Signals : memreadE, rdE, rs1D, rs2D, isbranchtakenE, branchtargetE, pcf,
//           dmem_reqM, dmem_readyM (to controller);
//           stallF/D/E/M, flushD/E/W, pc_redirect, mem_err (from controller).
// Option  : PIPE_HAZARD_PERF_EN adds perf_stall_cycles, perf_redirects, perf_loaduse.
interface pipeline_hazard_ctrl_if;
  logic        memreadE;
  logic [4:0]  rdE;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic        isbranchtakenE;
  logic [31:0] branchtargetE;
  logic [31:0] pcf;
  logic        dmem_reqM;
  logic        dmem_readyM;

  logic        stallF;
  logic        stallD;
  logic        stallE;
  logic        stallM;
  logic        flushD;
  logic        flushE;
  logic        flushW;
  logic        pc_redirect;
  logic        mem_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
  logic [31:0] perf_loaduse;
`endif

  modport master (
    output memreadE, rdE, rs1D, rs2D, isbranchtakenE, branchtargetE, pcf,
           dmem_reqM, dmem_readyM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW, pc_redirect, mem_err
`ifdef PIPE_HAZARD_PERF_EN
    , input perf_stall_cycles, perf_redirects, perf_loaduse
`endif
  );

  modport slave (
    input  memreadE, rdE, rs1D, rs2D, isbranchtakenE, branchtargetE, pcf,
           dmem_reqM, dmem_readyM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW, pc_redirect, mem_err
`ifdef PIPE_HAZARD_PERF_EN
    , output perf_stall_cycles, perf_redirects, perf_loaduse
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Purpose : stall/flush sequencer for the 5-stage pipeline. Fixed priority:
//           data-memory wait > taken-branch redirect > load-use. Owns a memory
//           wait FSM (RUN / MEM_WAIT / ERR) with timeout and a sticky error.
// Ports   : clk - rising-edge clock; rst - async active-high reset;
//           hz  - pipeline_hazard_ctrl_if.slave (hazard sources in, enables out).
// Option  : define PIPE_HAZARD_PERF_EN for the three 32-bit perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic mem_hold_c;
  logic redirect_c;
  logic loaduse_c;
  logic hold_fire_c;   // full pipeline freeze plus bubble into MEM/WB
  logic redir_fire_c;  // redirect actually applied this cycle
  logic lu_fire_c;     // load-use stall actually applied this cycle

  assign mem_hold_c = hz.dmem_reqM & ~hz.dmem_readyM;
  assign redirect_c = hz.isbranchtakenE & (hz.branchtargetE != hz.pcf);
  assign loaduse_c  = hz.memreadE & (hz.rdE != 5'd0) &
                      ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));

  // State, wait counter and sticky error register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state and hazard arbitration
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    hold_fire_c  = 1'b0;
    redir_fire_c = 1'b0;
    lu_fire_c    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_hold_c) begin
          hold_fire_c = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = CNT_W'(1);
        end else if (redirect_c) begin
          redir_fire_c = 1'b1;
        end else if (loaduse_c) begin
          lu_fire_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_hold_c) begin
          hold_fire_c = 1'b1;
          if (wait_cnt_q >= CNT_W'(MEM_TIMEOUT)) begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          // Ready or request withdrawn: the other sources are served in this same cycle
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (redirect_c) begin
            redir_fire_c = 1'b1;
          end else if (loaduse_c) begin
            lu_fire_c = 1'b1;
          end
        end
      end
      ST_ERR: begin
        hold_fire_c = 1'b1;
        mem_err_d   = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Enables are forced low while reset is asserted
  assign hz.stallF      = ~rst & (hold_fire_c | lu_fire_c);
  assign hz.stallD      = ~rst & (hold_fire_c | lu_fire_c);
  assign hz.stallE      = ~rst & hold_fire_c;
  assign hz.stallM      = ~rst & hold_fire_c;
  assign hz.flushW      = ~rst & hold_fire_c;
  assign hz.flushD      = ~rst & redir_fire_c;
  assign hz.flushE      = ~rst & (redir_fire_c | lu_fire_c);
  assign hz.pc_redirect = ~rst & redir_fire_c;
  assign hz.mem_err     = ~rst & mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_redir_q, perf_lu_q;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
      perf_lu_q    <= '0;
    end else begin
      if (hold_fire_c | lu_fire_c) perf_stall_q <= perf_stall_q + 32'd1;
      if (redir_fire_c)            perf_redir_q <= perf_redir_q + 32'd1;
      if (lu_fire_c)               perf_lu_q    <= perf_lu_q + 32'd1;
    end
  end

  assign hz.perf_stall_cycles = perf_stall_q;
  assign hz.perf_redirects    = perf_redir_q;
  assign hz.perf_loaduse      = perf_lu_q;
`endif

endmodule
